instr_fetch_ctrl: RTL

Sequences the instruction memory for the single-cycle/sequential core. Owns the program counter, drives the word address into the code memory, and captures the returned word into an output register. Presents the instruction to decode through a valid/ready handshake. Handles start, branch/jump redirect, halt-word detection and out-of-range faults.

---
 rtl/instr_fetch_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - instruction fetch sequencer: owns pc, drives code-memory address,
// captures words into a valid/ready output register, stops on halt word or out-of-range pc
module instr_fetch_ctrl #(
  parameter int                ADDR_W    = 32,
  parameter int                MEM_DEPTH = 256,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]       HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] pc_o,
  input  logic [31:0]       instr_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted,
  output logic              fault,
  output logic [31:0]       fetch_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] PC_LIMIT = ADDR_W'(MEM_DEPTH);

  state_t state;

  logic handshake;
  logic slot_free;
  logic pc_out_of_range;
  logic is_halt_word;

  assign handshake       = out_valid && out_ready;
  assign slot_free       = !out_valid || out_ready;
  assign pc_out_of_range = (pc_o >= PC_LIMIT);
  assign is_halt_word    = (instr_i == HALT_WORD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc_o        <= RESET_PC;
      out_valid   <= 1'b0;
      out_instr   <= 32'd0;
      out_pc      <= '0;
      halted      <= 1'b0;
      fault       <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      // Delivery counting is independent of state so late consumption in HALT still counts.
      if (handshake && (fetch_count != 32'hFFFF_FFFF)) begin
        fetch_count <= fetch_count + 32'd1;
      end

      case (state)
        IDLE: begin
          if (redirect_valid) begin
            pc_o <= redirect_pc;
          end
          if (start) begin
            state <= FETCH;
          end
        end

        FETCH: begin
          if (redirect_valid) begin
            pc_o      <= redirect_pc;
            out_valid <= 1'b0;
          end else if (pc_out_of_range) begin
            fault  <= 1'b1;
            halted <= 1'b1;
            state  <= HALT;
            if (handshake) begin
              out_valid <= 1'b0;
            end
          end else if (slot_free && is_halt_word) begin
            // pc stays on the halt word; an unconsumed held word remains presented
            halted <= 1'b1;
            state  <= HALT;
            if (handshake) begin
              out_valid <= 1'b0;
            end
          end else if (slot_free) begin
            out_instr <= instr_i;
            out_pc    <= pc_o;
            out_valid <= 1'b1;
            pc_o      <= pc_o + 1'b1;
          end
        end

        HALT: begin
          if (redirect_valid && !fault) begin
            halted    <= 1'b0;
            pc_o      <= redirect_pc;
            out_valid <= 1'b0;
            state     <= FETCH;
          end else if (handshake) begin
            out_valid <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
